// File: rtl/cpu_controller.sv
// cpu_controller: instruction register plus Moore control FSM.
// Latches one instruction when idle and start is high, decodes it and steps
// the datapath through register read, ALU and writeback. Every output is a
// function of the FSM state and the latched instruction only.
module cpu_controller (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] instr,
   output logic [15:0] datapath_in,
   output logic        wb_sel,
   output logic [2:0]  w_addr,
   output logic        w_en,
   output logic [2:0]  r_addr,
   output logic        en_A,
   output logic        en_B,
   output logic [1:0]  shift_op,
   output logic        sel_A,
   output logic        sel_B,
   output logic [1:0]  ALU_op,
   output logic        en_C,
   output logic        en_status,
   output logic        waiting
);

   localparam logic [2:0] S_WAIT   = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_WR_IMM = 3'd2;
   localparam logic [2:0] S_GET_A  = 3'd3;
   localparam logic [2:0] S_GET_B  = 3'd4;
   localparam logic [2:0] S_EXEC   = 3'd5;
   localparam logic [2:0] S_WB     = 3'd6;

   logic [2:0]  state_r;
   logic [2:0]  state_nx_s;
   logic [15:0] ir_r;

   // Instruction fields of the latched word.
   logic [2:0] opcode_s;
   logic [1:0] op_s;
   logic [2:0] rn_s;
   logic [2:0] rd_s;
   logic [1:0] sh_s;
   logic [2:0] rm_s;

   assign opcode_s = ir_r[15:13];
   assign op_s     = ir_r[12:11];
   assign rn_s     = ir_r[10:8];
   assign rd_s     = ir_r[7:5];
   assign sh_s     = ir_r[4:3];
   assign rm_s     = ir_r[2:0];

   // Instruction classes.
   logic is_mov_imm_s;
   logic is_mov_reg_s;
   logic is_alu_s;
   logic is_mvn_s;
   logic is_cmp_s;
   logic is_b_only_s;
   logic uses_a_s;

   assign is_mov_imm_s = (opcode_s == 3'b110) && (op_s == 2'b10);
   assign is_mov_reg_s = (opcode_s == 3'b110) && (op_s == 2'b00);
   assign is_alu_s     = (opcode_s == 3'b101);
   assign is_mvn_s     = is_alu_s && (op_s == 2'b11);
   assign is_cmp_s     = is_alu_s && (op_s == 2'b01);
   // MOV reg and MVN only need operand B; A is forced to zero in EXEC.
   assign is_b_only_s  = is_mov_reg_s || is_mvn_s;
   assign uses_a_s     = is_alu_s && !is_mvn_s;

   // Sign-extended immediate is always presented from the latched word.
   assign datapath_in = {{8{ir_r[7]}}, ir_r[7:0]};

   // State register and instruction register; IR only loads on leaving WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_WAIT;
         ir_r    <= 16'h0000;
      end else begin
         state_r <= state_nx_s;
         if ((state_r == S_WAIT) && start) begin
            ir_r <= instr;
         end
      end
   end

   // Next-state sequencing for each instruction class.
   always_comb begin
      state_nx_s = S_WAIT;
      case (state_r)
         S_WAIT: begin
            if (start) state_nx_s = S_DECODE;
            else       state_nx_s = S_WAIT;
         end
         S_DECODE: begin
            if (is_mov_imm_s)     state_nx_s = S_WR_IMM;
            else if (is_b_only_s) state_nx_s = S_GET_B;
            else if (uses_a_s)    state_nx_s = S_GET_A;
            else                  state_nx_s = S_WAIT;
         end
         S_WR_IMM: state_nx_s = S_WAIT;
         S_GET_A:  state_nx_s = S_GET_B;
         S_GET_B:  state_nx_s = S_EXEC;
         S_EXEC: begin
            if (is_cmp_s) state_nx_s = S_WAIT;
            else          state_nx_s = S_WB;
         end
         S_WB:     state_nx_s = S_WAIT;
         default:  state_nx_s = S_WAIT;
      endcase
   end

   // Moore output decode; unused addresses park on Rn so they never float.
   always_comb begin
      wb_sel    = 1'b0;
      w_addr    = rn_s;
      w_en      = 1'b0;
      r_addr    = rn_s;
      en_A      = 1'b0;
      en_B      = 1'b0;
      shift_op  = 2'b00;
      sel_A     = 1'b0;
      sel_B     = 1'b0;
      ALU_op    = 2'b00;
      en_C      = 1'b0;
      en_status = 1'b0;
      waiting   = 1'b0;
      case (state_r)
         S_WAIT: begin
            waiting = 1'b1;
         end
         S_DECODE: begin
            waiting = 1'b0;
         end
         S_WR_IMM: begin
            wb_sel = 1'b1;
            w_addr = rn_s;
            w_en   = 1'b1;
         end
         S_GET_A: begin
            r_addr = rn_s;
            en_A   = 1'b1;
         end
         S_GET_B: begin
            r_addr = rm_s;
            en_B   = 1'b1;
         end
         S_EXEC: begin
            shift_op = sh_s;
            sel_A    = is_b_only_s;
            if (is_mov_reg_s) ALU_op = 2'b00;
            else              ALU_op = op_s;
            if (is_cmp_s) en_status = 1'b1;
            else          en_C      = 1'b1;
         end
         S_WB: begin
            wb_sel = 1'b0;
            w_addr = rd_s;
            w_en   = 1'b1;
         end
         default: begin
            waiting = 1'b0;
         end
      endcase
   end

endmodule
